// File: rtl/load_extend_ctrl.sv
// Load sequencer between the MEM stage and data memory: issues one aligned word read
// per load, then selects and sign/zero-extends the addressed byte/halfword for writeback.
module load_extend_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        LdValid,
  output logic        LdReady,
  input  logic [1:0]  LdSize,
  input  logic        LdUnsigned,
  input  logic [31:0] LdAddr,
  input  logic [4:0]  LdRd,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        WbValid,
  output logic [31:0] WbData,
  output logic [4:0]  WbRd,
  output logic        Stall,
  output logic        AlignErr,
  output logic        TimeoutErr,
  output logic [1:0]  dbg_state
);

  // Handshake: a load transfers on the rising edge where LdValid & LdReady are both 1;
  // LdReady is high only in IDLE and LdValid is ignored at all other times (no queueing).

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic          err_to_q;

  logic          accept;
  logic          misaligned;
  logic          timeout_hit;
  logic          ack_hit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext_data;

  assign accept     = (state_q == S_IDLE) && LdValid;
  assign misaligned = ((LdSize == 2'b01) && LdAddr[0])
                    | ((LdSize == 2'b10) && (LdAddr[1:0] != 2'b00))
                    | (LdSize == 2'b11);
  assign ack_hit     = (state_q == S_REQ) && MemAck;
  // An ack in the last permitted cycle still wins over the timeout.
  assign timeout_hit = (state_q == S_REQ) && !MemAck && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (LdValid) state_d = misaligned ? S_ERR : S_REQ;
      S_REQ: begin
        if (MemAck)           state_d = S_WB;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Little-endian lane selection from the word returned by memory.
  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0: byte_sel = MemRdata[7:0];
      2'd1: byte_sel = MemRdata[15:8];
      2'd2: byte_sel = MemRdata[23:16];
      2'd3: byte_sel = MemRdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? MemRdata[31:16] : MemRdata[15:0];
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ext_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data = MemRdata;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q    <= '0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      rd_q     <= 5'd0;
      MemAddr  <= 32'h0;
      err_to_q <= 1'b0;
      WbData   <= 32'h0;
      WbRd     <= 5'd0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        size_q   <= LdSize;
        uns_q    <= LdUnsigned;
        off_q    <= LdAddr[1:0];
        rd_q     <= LdRd;
        MemAddr  <= {LdAddr[31:2], 2'b00};
        err_to_q <= 1'b0;
      end else if (state_q == S_REQ) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (timeout_hit) err_to_q <= 1'b1;
      if (ack_hit) begin
        WbData <= ext_data;
        WbRd   <= rd_q;
      end
    end
  end

  assign LdReady    = (state_q == S_IDLE);
  assign Stall      = ~LdReady;
  assign MemReq     = (state_q == S_REQ);
  assign WbValid    = (state_q == S_WB);
  assign AlignErr   = (state_q == S_ERR) && !err_to_q;
  assign TimeoutErr = (state_q == S_ERR) && err_to_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Directed bench for load_extend_ctrl: drivers push expected writeback/error events into
// exp_q, and a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_load_extend_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        LdValid = 1'b0;
  logic        LdReady;
  logic [1:0]  LdSize = 2'b00;
  logic        LdUnsigned = 1'b0;
  logic [31:0] LdAddr = 32'h0;
  logic [4:0]  LdRd = 5'd0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemRdata = 32'h0;
  logic        WbValid;
  logic [31:0] WbData;
  logic [4:0]  WbRd;
  logic        Stall;
  logic        AlignErr;
  logic        TimeoutErr;
  logic [1:0]  dbg_state;

  localparam int W = 39;  // {kind[1:0], rd[4:0], data[31:0]}; kind 0=wb 1=align 2=timeout

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;
  int n_vec = 0;
  int n_miss = 0;

  load_extend_ctrl #(.MEM_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .LdValid(LdValid), .LdReady(LdReady),
    .LdSize(LdSize), .LdUnsigned(LdUnsigned), .LdAddr(LdAddr), .LdRd(LdRd),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRdata(MemRdata),
    .WbValid(WbValid), .WbData(WbData), .WbRd(WbRd), .Stall(Stall),
    .AlignErr(AlignErr), .TimeoutErr(TimeoutErr), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    if (Reset_n && (WbValid || AlignErr || TimeoutErr)) begin
      mon_act = {(WbValid ? 2'd0 : (AlignErr ? 2'd1 : 2'd2)),
                 (WbValid ? WbRd : 5'd0), (WbValid ? WbData : 32'd0)};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL monitor_unexpected: got kind=%0d rd=%0d data=0x%08h, expected no output",
                 mon_act[38:37], mon_act[36:32], mon_act[31:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_miss++;
          $display("FAIL monitor_result: got kind=%0d rd=%0d data=0x%08h, expected kind=%0d rd=%0d data=0x%08h",
                   mon_act[38:37], mon_act[36:32], mon_act[31:0],
                   mon_exp[38:37], mon_exp[36:32], mon_exp[31:0]);
        end
      end
      if ((32'(WbValid) + 32'(AlignErr) + 32'(TimeoutErr)) > 1) begin
        n_miss++;
        $display("FAIL monitor_strobes: got WbValid=%0b AlignErr=%0b TimeoutErr=%0b, expected one strobe",
                 WbValid, AlignErr, TimeoutErr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_load(input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [4:0] rd);
    int guard = 0;
    while (!LdReady && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    check("ldready_before_issue", 32'(LdReady), 32'd1);
    LdValid = 1'b1; LdSize = size; LdUnsigned = uns; LdAddr = addr; LdRd = rd;
    @(negedge Clk);
    LdValid = 1'b0;
  endtask

  // Entered at the negedge of the first REQ cycle; ack is raised after 'delay' cycles.
  task automatic mem_respond(input int delay, input logic [31:0] rdata,
                             input logic [31:0] exp_addr);
    check("memreq_rise", 32'(MemReq), 32'd1);
    check("memaddr", MemAddr, exp_addr);
    check("stall_busy", 32'(Stall), 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge Clk);
      check("memreq_hold", 32'(MemReq), 32'd1);
    end
    MemAck = 1'b1; MemRdata = rdata;
    @(negedge Clk);
    MemAck = 1'b0; MemRdata = $urandom;
    check("wb_latency", 32'(WbValid), 32'd1);
    check("memreq_drop", 32'(MemReq), 32'd0);
    @(negedge Clk);
    check("wb_one_cycle", 32'(WbValid), 32'd0);
    check("ldready_after_wb", 32'(LdReady), 32'd1);
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp_data);
    exp_q.push_back({2'd0, rd, exp_data});
    start_load(size, uns, addr, rd);
    mem_respond(delay, rdata, {addr[31:2], 2'b00});
  endtask

  task automatic do_misaligned(input logic [1:0] size, input logic [31:0] addr,
                               input logic [4:0] rd);
    exp_q.push_back({2'd1, 5'd0, 32'd0});
    start_load(size, 1'b0, addr, rd);
    check("align_no_req", 32'(MemReq), 32'd0);
    check("align_no_wb", 32'(WbValid), 32'd0);
    @(negedge Clk);
    check("align_ready_after", 32'(LdReady), 32'd1);
    check("align_no_req_after", 32'(MemReq), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge Clk);
    check("rst_ldready", 32'(LdReady), 32'd1);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_wbvalid", 32'(WbValid), 32'd0);
    check("rst_wbdata", WbData, 32'd0);
    check("rst_wbrd", 32'(WbRd), 32'd0);
    check("rst_alignerr", 32'(AlignErr), 32'd0);
    check("rst_timeouterr", 32'(TimeoutErr), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // extraction and extension
    do_load(2'b00, 1'b0, 32'h0000_0103, 5'd1,  32'h80FF_1234, 3, 32'hFFFF_FF80);
    do_load(2'b00, 1'b1, 32'h0000_0103, 5'd2,  32'h80FF_1234, 0, 32'h0000_0080);
    do_load(2'b01, 1'b0, 32'h0000_0102, 5'd3,  32'h80FF_1234, 1, 32'hFFFF_80FF);
    do_load(2'b01, 1'b1, 32'h0000_0102, 5'd4,  32'h80FF_1234, 2, 32'h0000_80FF);
    do_load(2'b10, 1'b0, 32'h0000_0100, 5'd5,  32'h80FF_1234, 0, 32'h80FF_1234);
    do_load(2'b00, 1'b0, 32'h0000_0101, 5'd6,  32'h80FF_1234, 1, 32'h0000_0012);
    do_load(2'b01, 1'b0, 32'h0000_0100, 5'd7,  32'h80FF_1234, 0, 32'h0000_1234);
    do_load(2'b10, 1'b1, 32'hABCD_EF08, 5'd31, 32'hF000_000F, 0, 32'hF000_000F);

    // misaligned / illegal
    do_misaligned(2'b01, 32'h0000_0101, 5'd8);
    do_misaligned(2'b10, 32'h0000_0102, 5'd9);
    do_misaligned(2'b11, 32'h0000_0100, 5'd10);

    // timeout: 16 REQ cycles with no ack
    exp_q.push_back({2'd2, 5'd0, 32'd0});
    start_load(2'b10, 1'b0, 32'h0000_0200, 5'd11);
    check("to_memaddr", MemAddr, 32'h0000_0200);
    for (int i = 0; i < 16; i++) begin
      check("to_memreq_hold", 32'(MemReq), 32'd1);
      @(negedge Clk);
    end
    check("to_memreq_drop", 32'(MemReq), 32'd0);
    check("to_no_wb", 32'(WbValid), 32'd0);
    @(negedge Clk);
    check("to_ready_after", 32'(LdReady), 32'd1);
    MemAck = 1'b1; MemRdata = 32'h5555_AAAA;
    repeat (2) @(negedge Clk);
    MemAck = 1'b0;
    check("late_ack_no_req", 32'(MemReq), 32'd0);
    check("late_ack_no_wb", 32'(WbValid), 32'd0);

    // ack on the 16th REQ cycle still writes back
    do_load(2'b10, 1'b0, 32'h0000_0204, 5'd12, 32'hCAFE_F00D, 15, 32'hCAFE_F00D);

    // reset while in REQ
    start_load(2'b10, 1'b0, 32'h0000_0300, 5'd13);
    @(negedge Clk);
    check("pre_rst_memreq", 32'(MemReq), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_memreq", 32'(MemReq), 32'd0);
    check("async_rst_stall", 32'(Stall), 32'd0);
    check("async_rst_memaddr", MemAddr, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("post_rst_memreq", 32'(MemReq), 32'd0);
    check("post_rst_wb", 32'(WbValid), 32'd0);
    do_load(2'b01, 1'b1, 32'h0000_0302, 5'd14, 32'hFFFE_0001, 1, 32'h0000_FFFE);

    // back-to-back with LdValid held high and zero-wait memory
    exp_q.push_back({2'd0, 5'd20, 32'h1122_3344});
    exp_q.push_back({2'd0, 5'd21, 32'hFFFF_FFCC});
    LdValid = 1'b1; LdSize = 2'b10; LdUnsigned = 1'b0; LdAddr = 32'h0000_0400; LdRd = 5'd20;
    @(negedge Clk);
    LdSize = 2'b00; LdAddr = 32'h0000_0405; LdRd = 5'd21;
    check("b2b_a_memreq", 32'(MemReq), 32'd1);
    check("b2b_a_memaddr", MemAddr, 32'h0000_0400);
    MemAck = 1'b1; MemRdata = 32'h1122_3344;
    @(negedge Clk);
    MemAck = 1'b0;
    check("b2b_a_wb", 32'(WbValid), 32'd1);
    check("b2b_busy_not_ready", 32'(LdReady), 32'd0);
    @(negedge Clk);
    check("b2b_idle_ready", 32'(LdReady), 32'd1);
    check("b2b_b_not_taken_early", MemAddr, 32'h0000_0400);
    @(negedge Clk);
    LdValid = 1'b0;
    check("b2b_b_memreq", 32'(MemReq), 32'd1);
    check("b2b_b_memaddr", MemAddr, 32'h0000_0404);
    MemAck = 1'b1; MemRdata = 32'hAABB_CCDD;
    @(negedge Clk);
    MemAck = 1'b0;
    check("b2b_b_wb", 32'(WbValid), 32'd1);
    @(negedge Clk);
    check("b2b_end_ready", 32'(LdReady), 32'd1);

    repeat (3) @(negedge Clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
